// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

    localparam int PC_INC     = 4;
    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with push, pop, flush and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_s, full_s, do_push_s, do_pop_s;

    assign empty_s   = (cnt_q == '0);
    assign full_s    = (cnt_q == CW'(DEPTH));
    assign do_pop_s  = pop && !empty_s;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push_s = push && (!full_s || do_pop_s);
    assign head_data = mem_q[rd_q];
    assign count     = cnt_q;

    // Next pointers, count and storage; reset and flush empty the queue.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (reset || flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop_s) begin
                rd_d = rd_q + AW'(1);
            end else begin
                rd_d = rd_q;
            end
            cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited memory requests, response queue.
// Optional FETCH_PERF_EN adds saturating stall_cycles / flush_count counters.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [PC_W-1:0]   startpc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc,
    output logic [PC_W-1:0]   currentpc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]          discard_cnt_q, discard_cnt_d;
    fetch_state_e           state_q, state_d;
    logic [CW-1:0]          data_count_s, outstanding_s;
    logic [PC_W-1:0]        tag_head_s;
    logic [PC_W+INST_W-1:0] data_head_s;
    logic                   issue_s, rsp_fire_s, dropping_s, data_push_s, pop_s;

    // Outstanding requests are exactly the tags still waiting for a response.
    fetch_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(CLK), .reset(reset), .flush(1'b0),
        .push(issue_s), .push_data(fetch_pc_q), .pop(rsp_fire_s),
        .head_data(tag_head_s), .count(outstanding_s)
    );

    fetch_fifo #(.WIDTH(PC_W + INST_W), .DEPTH(DEPTH)) u_data_fifo (
        .clk(CLK), .reset(reset), .flush(redirect_valid),
        .push(data_push_s), .push_data({tag_head_s, imem_rsp_data}), .pop(pop_s),
        .head_data(data_head_s), .count(data_count_s)
    );

    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, data_count_s} + {1'b0, outstanding_s}) < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign currentpc      = fetch_pc_q;
    assign issue_s        = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding belongs to a pre-reset request and is ignored.
    assign rsp_fire_s     = !reset && imem_rsp_valid && (outstanding_s != '0);
    assign dropping_s     = (discard_cnt_q != '0);
    assign data_push_s    = rsp_fire_s && !dropping_s && !redirect_valid;
    assign inst_valid     = !reset && (data_count_s != '0);
    assign pop_s          = inst_valid && inst_ready;
    assign inst_data      = data_head_s[INST_W-1:0];
    assign inst_pc        = data_head_s[PC_W+INST_W-1:INST_W];

    // Fetch PC and discard count; a redirect marks every still-outstanding request stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_cnt_d = discard_cnt_q;
        if (reset) begin
            fetch_pc_d    = startpc;
            discard_cnt_d = '0;
        end else if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
            discard_cnt_d = outstanding_s - CW'(rsp_fire_s);
        end else begin
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_fire_s && dropping_s) begin
                discard_cnt_d = discard_cnt_q - CW'(1);
            end else begin
                discard_cnt_d = discard_cnt_q;
            end
        end
    end

    // Debug state: S_DRAIN while stale responses remain to be dropped.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   state_d = (redirect_valid && discard_cnt_d != '0) ? S_DRAIN : S_RUN;
                S_DRAIN: state_d = (discard_cnt_d == '0) ? S_RUN : S_DRAIN;
                default: state_d = S_RUN;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        fetch_pc_q    <= fetch_pc_d;
        discard_cnt_q <= discard_cnt_d;
        state_q       <= state_d;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (reset) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (inst_ready && !inst_valid && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end else begin
                stall_d = stall_q;
            end
            if (redirect_valid && flush_q != '1) begin
                flush_d = flush_q + 16'd1;
            end else begin
                flush_d = flush_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        stall_q <= stall_d;
        flush_q <= flush_d;
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
